// File: rtl/cache_req_arb.sv
// Two-requester arbiter in front of a cache with a registered request slot and in-order read-response routing.
// Optional macro CACHE_ARB_RR_EN selects round-robin arbitration; without it req0 has fixed priority.
package cache_req_arb_pkg;

  localparam logic RD_OP = 1'b0;
  localparam logic WR_OP = 1'b1;

  typedef struct packed {
    logic        valid;
    logic        opcode;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  byte_en;
    logic        sign_extend;
    logic [4:0]  reg_id;
  } t_req;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] data;
    logic [4:0]  reg_id;
  } t_rd_rsp;

endpackage

module cache_req_arb
  import cache_req_arb_pkg::*;
#(
  parameter int INFLIGHT_DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  t_req    req0,
  output logic    req0_ready,
  input  t_req    req1,
  output logic    req1_ready,
  output t_req    arb2cache_req,
  input  logic    cache_ready,
  input  t_rd_rsp cache2arb_rsp,
  output t_rd_rsp rsp0,
  output t_rd_rsp rsp1,
  output logic    err_unexp_rsp
);

  localparam int          PW       = $clog2(INFLIGHT_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(INFLIGHT_DEPTH);
  localparam logic [PW:0] CNT_ONE  = (PW + 1)'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [PW:0]               count;
  logic [PW-1:0]             wr_ptr;
  logic [PW-1:0]             rd_ptr;
  logic [INFLIGHT_DEPTH-1:0] id_mem;

  logic slot_free;
  logic fifo_full;
  logic fifo_empty;
  logic elig0;
  logic elig1;
  logic grant0;
  logic grant1;
  logic push;
  logic pop;
  logic pop_id;

`ifdef CACHE_ARB_RR_EN
  // prio=1 means requester 1 wins a tie on the next contested cycle.
  logic prio;
`endif

  always_comb begin
    slot_free  = !arb2cache_req.valid || cache_ready;
    // Registered count only: a pop this cycle does not make room for a read grant.
    fifo_full  = (count == FULL_CNT);
    fifo_empty = (count == '0);

    elig0 = req0.valid && slot_free && ((req0.opcode == WR_OP) || !fifo_full);
    elig1 = req1.valid && slot_free && ((req1.opcode == WR_OP) || !fifo_full);

`ifdef CACHE_ARB_RR_EN
    grant0 = elig0 && (!elig1 || !prio);
`else
    grant0 = elig0;
`endif
    grant1 = elig1 && !grant0;

    push   = (grant0 && (req0.opcode == RD_OP)) || (grant1 && (req1.opcode == RD_OP));
    pop    = cache2arb_rsp.valid && !fifo_empty;
    pop_id = id_mem[rd_ptr];
  end

  // Readys are forced low combinationally while reset is held, even with requests pending.
  assign req0_ready = rst_n && grant0;
  assign req1_ready = rst_n && grant1;

`ifdef CACHE_ARB_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio <= 1'b0;
    end else if (grant0) begin
      prio <= 1'b1;
    end else if (grant1) begin
      prio <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arb2cache_req <= '0;
    end else if (slot_free) begin
      if (grant0) begin
        arb2cache_req <= req0;
      end else if (grant1) begin
        arb2cache_req <= req1;
      end else begin
        arb2cache_req.valid <= 1'b0;
      end
    end
  end

  // ID storage needs no reset: only entries between rd_ptr and wr_ptr are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      id_mem[wr_ptr] <= grant1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0          <= '0;
      rsp1          <= '0;
      err_unexp_rsp <= 1'b0;
    end else begin
      rsp0       <= cache2arb_rsp;
      rsp0.valid <= pop && !pop_id;
      rsp1       <= cache2arb_rsp;
      rsp1.valid <= pop && pop_id;
      if (cache2arb_rsp.valid && fifo_empty) begin
        err_unexp_rsp <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cache_req_arb.sv
// Randomized and directed bench for cache_req_arb against a queue-based reference model.
module tb_cache_req_arb;
  import cache_req_arb_pkg::*;

  localparam int DEPTH = 4;

  logic    clk = 1'b0;
  logic    rst_n;
  t_req    req0, req1, arb2cache_req;
  logic    req0_ready, req1_ready, cache_ready, err_unexp_rsp;
  t_rd_rsp cache2arb_rsp, rsp0, rsp1;

  always #5 clk = ~clk;

  cache_req_arb #(.INFLIGHT_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req0          (req0),
    .req0_ready    (req0_ready),
    .req1          (req1),
    .req1_ready    (req1_ready),
    .arb2cache_req (arb2cache_req),
    .cache_ready   (cache_ready),
    .cache2arb_rsp (cache2arb_rsp),
    .rsp0          (rsp0),
    .rsp1          (rsp1),
    .err_unexp_rsp (err_unexp_rsp)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: request slot contents, in-flight requester IDs, cache-side pending reads.
  t_req    m_out;
  int      m_ids[$];
  t_req    cache_q[$];
  bit      m_prio;
  t_rd_rsp m_rsp0, m_rsp1;
  bit      m_err;

  int       pv0, pv1, prd0, prd1, pcr, prsp;
  bit       inject, hold0, hold1, g0, g1;
  logic [3:0] seq0 = '0, seq1 = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic knobs(input int a, input int b, input int c, input int d, input int e, input int f);
    pv0 = a; pv1 = b; prd0 = c; prd1 = d; pcr = e; prsp = f;
  endtask

  // reg_id[4] carries the requester number so routing can be cross-checked independently.
  function automatic t_req rand_req(input bit id, input int prd, input logic [3:0] seq);
    t_req r;
    r.valid       = 1'b1;
    r.opcode      = ($urandom_range(99) < prd) ? RD_OP : WR_OP;
    r.addr        = $urandom;
    r.data        = $urandom;
    r.byte_en     = 4'($urandom);
    r.sign_extend = 1'($urandom);
    r.reg_id      = {id, seq};
    return r;
  endfunction

  task automatic drive();
    t_req c;
    if (!hold0) begin
      req0 = rand_req(1'b0, prd0, seq0);
      if ($urandom_range(99) < pv0) seq0++; else req0.valid = 1'b0;
    end
    if (!hold1) begin
      req1 = rand_req(1'b1, prd1, seq1);
      if ($urandom_range(99) < pv1) seq1++; else req1.valid = 1'b0;
    end
    cache_ready          = ($urandom_range(99) < pcr);
    cache2arb_rsp.valid  = 1'b0;
    cache2arb_rsp.addr   = $urandom;
    cache2arb_rsp.data   = $urandom;
    cache2arb_rsp.reg_id = 5'($urandom);
    if (inject) begin
      cache2arb_rsp.valid = 1'b1;
      inject = 1'b0;
    end else if (cache_q.size() > 0 && $urandom_range(99) < prsp) begin
      c = cache_q.pop_front();
      cache2arb_rsp.valid  = 1'b1;
      cache2arb_rsp.addr   = c.addr;
      cache2arb_rsp.reg_id = c.reg_id;
    end
  endtask

  // One clock: drive at negedge, compare 1ns later, advance model across the posedge.
  task automatic step();
    int w, id;
    bit sf, full, e0, e1;
    t_rd_rsp r;
    drive();
    #1;
    sf   = !m_out.valid || cache_ready;
    full = (m_ids.size() >= DEPTH);
    e0   = req0.valid && sf && (req0.opcode == WR_OP || !full);
    e1   = req1.valid && sf && (req1.opcode == WR_OP || !full);
    w    = -1;
`ifdef CACHE_ARB_RR_EN
    if (e0 && e1) w = m_prio ? 1 : 0;
    else if (e0) w = 0;
    else if (e1) w = 1;
`else
    if (e0) w = 0;
    else if (e1) w = 1;
`endif
    chk("req0_ready", req0_ready, w == 0);
    chk("req1_ready", req1_ready, w == 1);
    chk("out_valid", arb2cache_req.valid, m_out.valid);
    if (m_out.valid) chk("out_req", arb2cache_req, m_out);
    chk("rsp0_valid", rsp0.valid, m_rsp0.valid);
    chk("rsp1_valid", rsp1.valid, m_rsp1.valid);
    if (m_rsp0.valid) chk("rsp0_data", rsp0, m_rsp0);
    if (m_rsp1.valid) chk("rsp1_data", rsp1, m_rsp1);
    if (rsp0.valid) chk("rsp0_src", rsp0.reg_id[4], 1'b0);
    if (rsp1.valid) chk("rsp1_src", rsp1.reg_id[4], 1'b1);
    chk("err_flag", err_unexp_rsp, m_err);
    g0 = req0_ready;
    g1 = req1_ready;
    hold0 = req0.valid && !req0_ready;
    hold1 = req1.valid && !req1_ready;

    if (m_out.valid && cache_ready && m_out.opcode == RD_OP) cache_q.push_back(m_out);
    m_rsp0.valid = 1'b0;
    m_rsp1.valid = 1'b0;
    if (cache2arb_rsp.valid) begin
      if (m_ids.size() > 0) begin
        id = m_ids.pop_front();
        r  = cache2arb_rsp;
        if (id == 0) m_rsp0 = r; else m_rsp1 = r;
      end else begin
        m_err = 1'b1;
      end
    end
    if (w == 0 && req0.opcode == RD_OP) m_ids.push_back(0);
    if (w == 1 && req1.opcode == RD_OP) m_ids.push_back(1);
    if (sf) begin
      if (w == 0) m_out = req0;
      else if (w == 1) m_out = req1;
      else m_out.valid = 1'b0;
    end
    if (w >= 0) m_prio = (w == 0);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0 = rand_req(1'b0, 100, 4'd0);
    req1 = rand_req(1'b1, 100, 4'd0);
    cache_ready = 1'b1;
    cache2arb_rsp.valid = 1'b1;
    #1;
    chk("rst_out_valid", arb2cache_req.valid, 1'b0);
    chk("rst_rsp0_valid", rsp0.valid, 1'b0);
    chk("rst_rsp1_valid", rsp1.valid, 1'b0);
    chk("rst_req0_ready", req0_ready, 1'b0);
    chk("rst_req1_ready", req1_ready, 1'b0);
    chk("rst_err", err_unexp_rsp, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_hold_ready", {req1_ready, req0_ready}, 2'b00);
    rst_n = 1'b1;
    m_out = '0; m_rsp0 = '0; m_rsp1 = '0;
    m_ids.delete(); cache_q.delete();
    m_prio = 1'b0; m_err = 1'b0;
    hold0 = 1'b0; hold1 = 1'b0; inject = 1'b0;
  endtask

  initial begin
    int ng, nr0, nr1;
    t_req saved;
    logic [1:0] exp_g;
    cache2arb_rsp = '0;
    do_reset();

    // Both requesters stream reads with a fully ready cache.
    knobs(100, 100, 100, 100, 100, 100);
    ng = 0;
    for (int i = 0; i < 8; i++) begin
      step();
`ifdef CACHE_ARB_RR_EN
      exp_g = (i % 2 == 1) ? 2'b10 : 2'b01;
`else
      exp_g = 2'b01;
`endif
      chk("grant_seq", {g1, g0}, exp_g);
      if (g0 || g1) ng++;
    end
    chk("grants_in_8", ng, 8);
    knobs(0, 0, 100, 100, 100, 100);
    for (int i = 0; i < 12; i++) step();

    // Stalled cache holds the slot; release loads the next winner in the same cycle.
    do_reset();
    knobs(100, 0, 100, 100, 0, 0);
    step();
    saved = req0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_out", arb2cache_req, saved);
      chk("stall_ready", {g1, g0}, 2'b00);
    end
    pcr = 100;
    step();
    chk("release_r0", g0, 1'b1);
    chk("next_load", arb2cache_req, req0);

    // Fill the in-flight FIFO; writes still flow, reads wait for a pop from the previous cycle.
    do_reset();
    knobs(100, 0, 100, 100, 100, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("fill_r0", g0, 1'b1);
    end
    knobs(100, 100, 100, 0, 100, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("full_r0", g0, 1'b0);
      chk("full_wr_r1", g1, 1'b1);
    end
    knobs(100, 0, 100, 0, 100, 100);
    step();
    chk("pop_same_cycle_r0", g0, 1'b0);
    prsp = 0;
    step();
    chk("after_pop_r0", g0, 1'b1);
    knobs(0, 0, 100, 100, 100, 100);
    for (int i = 0; i < 12; i++) step();

    // Unexpected response with nothing in flight.
    do_reset();
    knobs(0, 0, 100, 100, 100, 100);
    inject = 1'b1;
    step();
    chk("err_set", err_unexp_rsp, 1'b1);
    chk("err_no_rsp", {rsp1.valid, rsp0.valid}, 2'b00);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("err_hold", err_unexp_rsp, 1'b1);
    end

    // Reset with reads in flight; no stale responses afterwards.
    do_reset();
    knobs(100, 0, 100, 100, 100, 0);
    for (int i = 0; i < 3; i++) step();
    do_reset();
    knobs(0, 100, 100, 100, 100, 100);
    nr0 = 0; nr1 = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (rsp0.valid) nr0++;
      if (rsp1.valid) nr1++;
    end
    chk("stale_rsp0", nr0, 0);
    chk("new_rsp1_seen", nr1 > 0, 1'b1);

    // Randomized traffic with occasional resets and unexpected responses.
    for (int round = 0; round < 20; round++) begin
      if ($urandom_range(99) < 30) do_reset();
      knobs($urandom_range(100), $urandom_range(100), $urandom_range(100),
            $urandom_range(100), $urandom_range(20, 100), $urandom_range(100));
      for (int i = 0; i < 150; i++) begin
        if (m_ids.size() == 0 && $urandom_range(99) < 2) inject = 1'b1;
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
